// File: rtl/cnn_pkg.sv
// Shared CNN definitions: element width, window/filter element ordering, counter widths.
package cnn_pkg;

  localparam int DATA_WIDTH = 16;

  // Flattened element index shared by window generator and filter loader.
  function automatic int idx(input int d, input int r, input int c, input int f);
    return (d * f + r) * f + c;
  endfunction

  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// F-1 stacked image rows addressed by column; read-before-write shift on each pixel.
module conv_line_buffer #(
  parameter int PW = 16,
  parameter int F  = 5,
  parameter int W  = 32,
  parameter int CW = cnn_pkg::cw(W)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [CW-1:0]        col,
  input  logic [PW-1:0]        din,
  output logic [F-2:0][PW-1:0] col_out
);

  // Entry 0 holds the oldest row (top of the window), entry F-2 the newest.
  logic [F-2:0][PW-1:0] mem [W];

  assign col_out = mem[col];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < F-2; i++) mem[col][i] <= mem[col][i+1];
      mem[col][F-2] <= din;
    end
  end

endmodule

// File: rtl/conv_window_generator.sv
// Raster-order pixel stream in, FxF (xD) valid-convolution windows out, stride 1.
module conv_window_generator #(
  parameter int DATA_WIDTH = cnn_pkg::DATA_WIDTH,
  parameter int D          = 1,
  parameter int F          = 5,
  parameter int W          = 32,
  parameter int H          = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [D*DATA_WIDTH-1:0]       in_pixel,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [D*F*F*DATA_WIDTH-1:0]   win_data,
  output logic                          win_valid,
  input  logic                          win_ready,
  output logic [cnn_pkg::cw(H)-1:0]     win_row,
  output logic [cnn_pkg::cw(W)-1:0]     win_col,
  output logic                          win_last
);
  import cnn_pkg::*;

  localparam int PW = D * DATA_WIDTH;
  localparam int RW = cw(H);
  localparam int CW = cw(W);
  localparam logic [RW-1:0] ROW_FIRST = RW'(F-1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(H-1);
  localparam logic [CW-1:0] COL_FIRST = CW'(F-1);
  localparam logic [CW-1:0] COL_LAST  = CW'(W-1);

  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [F-1:0][F-1:0][PW-1:0] wreg;  // [r][c], c=0 is the leftmost column
  logic [F-2:0][PW-1:0] lb_col;
  logic accept, emit, eol, eof;

  assign in_ready = !win_valid || win_ready;
  assign accept   = in_valid && in_ready;
  assign emit     = (row >= ROW_FIRST) && (col >= COL_FIRST);
  assign eol      = (col == COL_LAST);
  assign eof      = eol && (row == ROW_LAST);

  conv_line_buffer #(.PW(PW), .F(F), .W(W), .CW(CW)) u_lb (
    .clk     (clk),
    .we      (accept),
    .col     (col),
    .din     (in_pixel),
    .col_out (lb_col)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      row       <= '0;
      col       <= '0;
      wreg      <= '0;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
    end else if (accept) begin
      for (int r = 0; r < F; r++)
        for (int c = 0; c < F-1; c++) wreg[r][c] <= wreg[r][c+1];
      for (int r = 0; r < F-1; r++) wreg[r][F-1] <= lb_col[r];
      wreg[F-1][F-1] <= in_pixel;
      col <= eol ? '0 : col + 1'b1;
      if (eol) row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      win_valid <= emit;
      win_last  <= emit && eof;
      if (emit) begin
        win_row <= row - ROW_FIRST;
        win_col <= col - COL_FIRST;
      end
    end else if (win_ready) begin
      win_valid <= 1'b0;
    end
  end

  // Input is stalled while a window is held, so wreg drives the output directly.
  for (genvar d = 0; d < D; d++) begin : g_d
    for (genvar r = 0; r < F; r++) begin : g_r
      for (genvar c = 0; c < F; c++) begin : g_c
        assign win_data[DATA_WIDTH*idx(d, r, c, F) +: DATA_WIDTH] =
          wreg[r][c][DATA_WIDTH*d +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_conv_window_generator.sv
// Directed bench: 6x6 image, 3x3 window, D=1 and D=2 instances driven in lockstep.
module tb_conv_window_generator;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic win_ready = 1'b1;
  logic [15:0] pix0 = '0;
  logic [31:0] pix1 = '0;

  logic rdy0, wv0, wl0, rdy1, wv1, wl1;
  logic [2:0] wr0, wc0, wr1, wc1;
  logic [143:0] wd0;
  logic [287:0] wd1;

  always #5 clk = ~clk;

  conv_window_generator #(.DATA_WIDTH(16), .D(1), .F(3), .W(6), .H(6)) u0 (
    .clk(clk), .reset(reset), .in_pixel(pix0), .in_valid(in_valid), .in_ready(rdy0),
    .win_data(wd0), .win_valid(wv0), .win_ready(win_ready), .win_row(wr0),
    .win_col(wc0), .win_last(wl0));

  conv_window_generator #(.DATA_WIDTH(16), .D(2), .F(3), .W(6), .H(6)) u1 (
    .clk(clk), .reset(reset), .in_pixel(pix1), .in_valid(in_valid), .in_ready(rdy1),
    .win_data(wd1), .win_valid(wv1), .win_ready(win_ready), .win_row(wr1),
    .win_col(wc1), .win_last(wl1));

  typedef struct {int r; int c; int k0; int k8; int last;} vec_t;
  typedef struct {int row; int col; int last; int row1; int col1; int last1;
                  logic [143:0] d0; logic [287:0] d1;} rec_t;

  vec_t tbl[16];
  rec_t q[$];
  int nchk = 0;
  int nerr = 0;
  int w00[9] = '{0, 1, 2, 6, 7, 8, 12, 13, 14};
  logic [143:0] snap;

  always @(negedge clk) begin
    rec_t e;
    if (!reset && wv0 && win_ready) begin
      e.row = int'(wr0); e.col = int'(wc0); e.last = int'(wl0);
      e.row1 = int'(wr1); e.col1 = int'(wc1); e.last1 = int'(wl1);
      e.d0 = wd0; e.d1 = wd1;
      q.push_back(e);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_pix(input int v);
    pix0 = 16'(v);
    pix1 = {16'(v + 50), 16'(v)};
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic push(input int v);
    bit acc = 1'b0;
    int g = 0;
    set_pix(v);
    in_valid = 1'b1;
    while (!acc && g < 50) begin
      @(negedge clk);
      acc = rdy0;
      @(posedge clk);
      #1;
      g++;
    end
    if (!acc) chk("push_timeout", 0, 1);
  endtask

  task automatic stream(input int base, input int from, input int to, input bit lat);
    for (int p = from; p <= to; p++) begin
      push(base + p);
      if (lat) begin
        chk($sformatf("lat_valid_p%0d", p), int'(wv0), int'((p / 6 >= 2) && (p % 6 >= 2)));
        chk($sformatf("lat_valid1_p%0d", p), int'(wv1), int'(wv0));
        chk($sformatf("lat_last_p%0d", p), int'(wl0), int'(p == 35));
      end
    end
  endtask

  task automatic drain();
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input int off, input int base);
    if (q.size() < off + 16) begin
      chk("frame_win_count", q.size(), off + 16);
      return;
    end
    for (int i = 0; i < 16; i++) begin
      rec_t e = q[off + i];
      vec_t t = tbl[i];
      chk($sformatf("w%0d_row", off + i), e.row, t.r);
      chk($sformatf("w%0d_col", off + i), e.col, t.c);
      chk($sformatf("w%0d_last", off + i), e.last, t.last);
      chk($sformatf("w%0d_k8", off + i), int'(e.d0[128 +: 16]), t.k8 + base);
      chk($sformatf("w%0d_d2_pos", off + i), e.row1 * 8 + e.col1 * 2 + e.last1,
          t.r * 8 + t.c * 2 + t.last);
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) begin
          int k = r * 3 + c;
          int ex = t.k0 + base + r * 6 + c;
          chk($sformatf("w%0d_k%0d", off + i, k), int'(e.d0[16*k +: 16]), ex);
          chk($sformatf("w%0d_d2_k%0d", off + i, k), int'(e.d1[16*k +: 16]), ex);
          chk($sformatf("w%0d_d2_k%0d", off + i, k + 9), int'(e.d1[16*(k+9) +: 16]), ex + 50);
        end
    end
  endtask

  initial begin
    tbl[0]  = '{0, 0, 0, 14, 0};   tbl[1]  = '{0, 1, 1, 15, 0};
    tbl[2]  = '{0, 2, 2, 16, 0};   tbl[3]  = '{0, 3, 3, 17, 0};
    tbl[4]  = '{1, 0, 6, 20, 0};   tbl[5]  = '{1, 1, 7, 21, 0};
    tbl[6]  = '{1, 2, 8, 22, 0};   tbl[7]  = '{1, 3, 9, 23, 0};
    tbl[8]  = '{2, 0, 12, 26, 0};  tbl[9]  = '{2, 1, 13, 27, 0};
    tbl[10] = '{2, 2, 14, 28, 0};  tbl[11] = '{2, 3, 15, 29, 0};
    tbl[12] = '{3, 0, 18, 32, 0};  tbl[13] = '{3, 1, 19, 33, 0};
    tbl[14] = '{3, 2, 20, 34, 0};  tbl[15] = '{3, 3, 21, 35, 1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", int'(wv0), 0);
    chk("rst_last", int'(wl0), 0);
    chk("rst_row", int'(wr0), 0);
    chk("rst_col", int'(wc0), 0);
    chk("rst_data_zero", int'(wd0 == '0), 1);
    chk("rst_data1_zero", int'(wd1 == '0), 1);
    chk("rst_in_ready", int'(rdy0), 1);
    reset = 1'b0;

    // Full frame, first-window latency, window order, last flag
    q.delete();
    stream(0, 0, 35, 1'b1);
    drain();
    chk("frame1_count", q.size(), 16);
    if (q.size() > 0) begin
      for (int k = 0; k < 9; k++) begin
        chk($sformatf("first_k%0d", k), int'(q[0].d0[16*k +: 16]), w00[k]);
        chk($sformatf("first_d2_k%0d", k + 9), int'(q[0].d1[16*(k+9) +: 16]), w00[k] + 50);
      end
    end
    check_frame(0, 0);

    // Backpressure on the first window, then back-to-back frames
    do_reset();
    q.delete();
    stream(0, 0, 14, 1'b0);
    win_ready = 1'b0;
    snap = wd0;
    set_pix(15);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_in_ready_%0d", i), int'(rdy0), 0);
      chk($sformatf("bp_in_ready1_%0d", i), int'(rdy1), 0);
      chk($sformatf("bp_valid_%0d", i), int'(wv0), 1);
      chk($sformatf("bp_stable_%0d", i), int'(wd0 == snap), 1);
      chk($sformatf("bp_col_%0d", i), int'(wc0), 0);
      @(posedge clk);
      #1;
    end
    chk("bp_none_taken", q.size(), 0);
    win_ready = 1'b1;
    stream(0, 15, 35, 1'b0);
    stream(100, 0, 35, 1'b0);
    drain();
    chk("b2b_count", q.size(), 32);
    check_frame(0, 0);
    check_frame(16, 100);

    // Reset mid-frame, then a clean frame
    do_reset();
    q.delete();
    stream(0, 0, 20, 1'b0);
    reset = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("midrst_valid", int'(wv0), 0);
    q.delete();
    stream(0, 0, 35, 1'b1);
    drain();
    chk("midrst_count", q.size(), 16);
    check_frame(0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
